// File: rtl/pfu_mmu_pe_arb.sv
// pfu_mmu_pe_arb
// Arbitrates L1/L2 translation requests from the 8 prefetch-buffer entries
// onto the single MMU prefetch port. One transaction at a time:
// IDLE (grant) -> REQ (MMU handshake) -> WAIT (response) -> IDLE.
// Round-robin across entries starting at rr_ptr; L1 beats L2 within an entry.
// A popped entry still completes its MMU handshake but its response is dropped.
//
// Optional feature: define PFU_MMU_ARB_TIMEOUT_EN to add an 8-bit WAIT
// watchdog that returns an error response after 255 silent WAIT cycles.
//
// Handshakes: lsu_mmu_pfu_req is valid and lsu_mmu_pfu_vpn is stable from
// the first REQ cycle until the cycle where mmu_lsu_pfu_grnt is sampled high;
// a response is accepted only while in WAIT, in the cycle mmu_lsu_pfu_ppn_vld=1.
module pfu_mmu_pe_arb (
  input  logic         forever_cpuclk,
  input  logic         cpurst,
  input  logic         pfu_dcache_pref_en,
  input  logic         cp0_lsu_pfu_mmu_dis,
  input  logic [7:0]   entry_mmu_pe_req_l1,
  input  logic [7:0]   entry_mmu_pe_req_l2,
  input  logic [223:0] entry_l1_vpn,
  input  logic [223:0] entry_l2_vpn,
  input  logic [7:0]   entry_pop_vld,
  input  logic         mmu_lsu_pfu_grnt,
  input  logic         mmu_lsu_pfu_ppn_vld,
  input  logic [27:0]  mmu_lsu_pfu_ppn,
  input  logic         mmu_lsu_pfu_ppn_err,
  input  logic         mmu_lsu_pfu_sec,
  input  logic         mmu_lsu_pfu_share,
  output logic         lsu_mmu_pfu_req,
  output logic [27:0]  lsu_mmu_pfu_vpn,
  output logic [7:0]   entry_mmu_pe_req_grnt,
  output logic         pfu_mmu_pe_req_sel_l1,
  output logic [7:0]   pfu_get_ppn_vld,
  output logic [27:0]  pfu_get_ppn,
  output logic         pfu_get_ppn_err,
  output logic         pfu_get_page_sec,
  output logic         pfu_get_page_share,
  output logic         arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [2:0]  rr_ptr_q;
  logic        kill_q;
  logic [2:0]  idx_q;
  logic        src_l1_q;
  logic [27:0] vpn_q;

  logic [27:0] l1_vpn_arr [8];
  logic [27:0] l2_vpn_arr [8];
  logic        win_found;
  logic [2:0]  win_idx;
  logic        win_l1;
  logic [2:0]  cand;
  logic [27:0] win_vpn;
  logic        grant_go;
  logic        kill_now;
  logic        resp_take;
  logic        timeout_fire;
  logic        resp_fire;

  // Split the flat VPN buses into per-entry views.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      l1_vpn_arr[i] = entry_l1_vpn[i*28 +: 28];
      l2_vpn_arr[i] = entry_l2_vpn[i*28 +: 28];
    end
  end

  // Round-robin scan from rr_ptr; first requesting entry wins, L1 before L2.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    win_l1    = 1'b0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = rr_ptr_q + 3'(i);
      if (!win_found && (entry_mmu_pe_req_l1[cand] || entry_mmu_pe_req_l2[cand])) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_l1    = entry_mmu_pe_req_l1[cand];
      end
    end
  end

  assign win_vpn  = win_l1 ? l1_vpn_arr[win_idx] : l2_vpn_arr[win_idx];

  // Grants only from IDLE, and never while reset is held.
  assign grant_go = (state_q == ST_IDLE) && !cpurst && win_found &&
                    pfu_dcache_pref_en && !cp0_lsu_pfu_mmu_dis;

  assign kill_now  = entry_pop_vld[idx_q];
  assign resp_take = (state_q == ST_WAIT) && mmu_lsu_pfu_ppn_vld;

`ifdef PFU_MMU_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  assign timeout_fire = (state_q == ST_WAIT) && !mmu_lsu_pfu_ppn_vld && (wait_cnt_q == 8'hFF);

  // Watchdog: counts WAIT cycles, cleared when WAIT is entered.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      wait_cnt_q <= 8'd0;
    end else if (state_q == ST_REQ && mmu_lsu_pfu_grnt) begin
      wait_cnt_q <= 8'd0;
    end else if (state_q == ST_WAIT && wait_cnt_q != 8'hFF) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // A pop seen earlier (kill_q) or in the response cycle itself drops the response.
  assign resp_fire = (resp_take || timeout_fire) && !kill_q && !kill_now;

  assign entry_mmu_pe_req_grnt = grant_go ? (8'd1 << win_idx) : 8'd0;
  assign pfu_mmu_pe_req_sel_l1 = grant_go ? win_l1 : src_l1_q;
  assign lsu_mmu_pfu_req       = (state_q == ST_REQ);
  assign lsu_mmu_pfu_vpn       = vpn_q;
  assign pfu_get_ppn_vld       = resp_fire ? (8'd1 << idx_q) : 8'd0;
  assign pfu_get_ppn           = mmu_lsu_pfu_ppn;
  assign pfu_get_ppn_err       = timeout_fire || (mmu_lsu_pfu_ppn_err && !cpurst);
  assign pfu_get_page_sec      = mmu_lsu_pfu_sec;
  assign pfu_get_page_share    = mmu_lsu_pfu_share;
  assign arb_busy              = (state_q != ST_IDLE);

  // Main FSM: latch the winner on grant, track kills, return to IDLE on response.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 3'd0;
      kill_q   <= 1'b0;
      idx_q    <= 3'd0;
      src_l1_q <= 1'b0;
      vpn_q    <= 28'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          kill_q <= 1'b0;
          if (grant_go) begin
            idx_q    <= win_idx;
            src_l1_q <= win_l1;
            vpn_q    <= win_vpn;
            rr_ptr_q <= win_idx + 3'd1;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (kill_now) kill_q <= 1'b1;
          if (mmu_lsu_pfu_grnt) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (kill_now) kill_q <= 1'b1;
          if (resp_take || timeout_fire) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          kill_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pfu_mmu_pe_arb.sv
// Bench for pfu_mmu_pe_arb: grant-decision table, multi-cycle transaction
// sequences and a response scoreboard. Define PFU_MMU_ARB_TIMEOUT_EN for the
// watchdog sequence.
module tb_pfu_mmu_pe_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         pref_en, mmu_dis;
  logic [7:0]   req_l1, req_l2, pop;
  logic [223:0] l1_vpn, l2_vpn;
  logic         mmu_grnt, ppn_vld_in, ppn_err_in, sec_in, share_in;
  logic [27:0]  ppn_in;
  logic         lsu_req;
  logic [27:0]  lsu_vpn;
  logic [7:0]   grnt;
  logic         sel_l1;
  logic [7:0]   get_vld;
  logic [27:0]  get_ppn;
  logic         get_err, get_sec, get_share, busy;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [38:0] exp_q[$];

  typedef struct {
    logic [7:0] l1;
    logic [7:0] l2;
    logic       pref;
    logic       dis;
    logic [7:0] exp_grnt;
    logic       exp_sel;
  } vec_t;
  vec_t vecs[10];

  pfu_mmu_pe_arb dut (
    .forever_cpuclk        (clk),
    .cpurst                (rst),
    .pfu_dcache_pref_en    (pref_en),
    .cp0_lsu_pfu_mmu_dis   (mmu_dis),
    .entry_mmu_pe_req_l1   (req_l1),
    .entry_mmu_pe_req_l2   (req_l2),
    .entry_l1_vpn          (l1_vpn),
    .entry_l2_vpn          (l2_vpn),
    .entry_pop_vld         (pop),
    .mmu_lsu_pfu_grnt      (mmu_grnt),
    .mmu_lsu_pfu_ppn_vld   (ppn_vld_in),
    .mmu_lsu_pfu_ppn       (ppn_in),
    .mmu_lsu_pfu_ppn_err   (ppn_err_in),
    .mmu_lsu_pfu_sec       (sec_in),
    .mmu_lsu_pfu_share     (share_in),
    .lsu_mmu_pfu_req       (lsu_req),
    .lsu_mmu_pfu_vpn       (lsu_vpn),
    .entry_mmu_pe_req_grnt (grnt),
    .pfu_mmu_pe_req_sel_l1 (sel_l1),
    .pfu_get_ppn_vld       (get_vld),
    .pfu_get_ppn           (get_ppn),
    .pfu_get_ppn_err       (get_err),
    .pfu_get_page_sec      (get_sec),
    .pfu_get_page_share    (get_share),
    .arb_busy              (busy)
  );

  // Clock and run-time bound
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "simulation time bound expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    pref_en = 1'b1; mmu_dis = 1'b0;
    req_l1 = 8'h00; req_l2 = 8'h00; pop = 8'h00;
    mmu_grnt = 1'b0; ppn_vld_in = 1'b0; ppn_err_in = 1'b0;
    sec_in = 1'b0; share_in = 1'b0; ppn_in = 28'd0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Response scoreboard: every DUT response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (get_vld != 8'h00)) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL resp_unexpected: got vld 0x%0h, required none", get_vld);
      end else begin
        check("resp_scoreboard", {get_vld, get_ppn, get_err, get_sec, get_share}, exp_q.pop_front());
      end
    end
  end

  // Drives one full transaction starting in its grant cycle.
  // kill: 0 none, 1 pop in WAIT before response, 2 pop with response, 3 pop other entry.
  task automatic serve(input int ent, input logic l1, input logic [27:0] vpn, input int bp,
                       input logic [27:0] ppn, input logic err, input int kill);
    logic [7:0] oh;
    oh = 8'd1 << ent;
    smp();
    check("grant_onehot", grnt, oh);
    check("grant_sel_l1", sel_l1, l1);
    tick();
    for (int k = 0; k < bp; k++) begin
      smp();
      check("bp_req_held", lsu_req, 1);
      check("bp_vpn_held", lsu_vpn, vpn);
      tick();
    end
    mmu_grnt = 1'b1;
    smp();
    check("req_valid", lsu_req, 1);
    check("req_vpn", lsu_vpn, vpn);
    check("req_sel_latched", sel_l1, l1);
    check("req_no_grant", grnt, 0);
    tick();
    mmu_grnt = 1'b0;
    if (kill == 1) begin
      pop[ent] = 1'b1;
      smp();
      check("wait_busy", busy, 1);
      tick();
      pop = 8'h00;
    end
    if (kill == 2) pop[ent] = 1'b1;
    if (kill == 3) pop[(ent + 1) % 8] = 1'b1;
    ppn_vld_in = 1'b1; ppn_in = ppn; ppn_err_in = err;
    sec_in = ppn[0]; share_in = ppn[1];
    if (kill == 0 || kill == 3) exp_q.push_back({oh, ppn, err, ppn[0], ppn[1]});
    smp();
    check("resp_vld", get_vld, (kill == 1 || kill == 2) ? 8'h00 : oh);
    tick();
    ppn_vld_in = 1'b0; ppn_err_in = 1'b0; pop = 8'h00;
  endtask

  initial begin
    vecs[0] = '{8'h01, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1};
    vecs[1] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'h01, 1'b0};
    vecs[2] = '{8'h80, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1};
    vecs[3] = '{8'h00, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0};
    vecs[4] = '{8'h10, 8'h04, 1'b1, 1'b0, 8'h04, 1'b0};
    vecs[5] = '{8'h20, 8'h20, 1'b1, 1'b0, 8'h20, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[9] = '{8'h40, 8'h81, 1'b1, 1'b0, 8'h01, 1'b0};

    for (int i = 0; i < 8; i++) begin
      l1_vpn[i*28 +: 28] = 28'h0100000 + 28'(i);
      l2_vpn[i*28 +: 28] = 28'h0200000 + 28'(i);
    end

    // Reset: outputs quiet even with live inputs; data fields pass through.
    clear_inputs();
    rst = 1'b1;
    req_l1 = 8'hFF; ppn_vld_in = 1'b1; ppn_err_in = 1'b1;
    ppn_in = 28'h5A5A5A5; sec_in = 1'b1; share_in = 1'b1;
    smp();
    check("rst_grnt", grnt, 0);
    check("rst_sel", sel_l1, 0);
    check("rst_req", lsu_req, 0);
    check("rst_vpn", lsu_vpn, 0);
    check("rst_vld", get_vld, 0);
    check("rst_err", get_err, 0);
    check("rst_busy", busy, 0);
    check("rst_ppn_pass", {get_ppn, get_sec, get_share}, {28'h5A5A5A5, 2'b11});
    tick();
    clear_inputs();
    rst = 1'b0;

    // Grant decision table, each vector from a fresh reset (rr_ptr=0).
    for (int i = 0; i < 10; i++) begin
      pulse_reset();
      req_l1 = vecs[i].l1; req_l2 = vecs[i].l2;
      pref_en = vecs[i].pref; mmu_dis = vecs[i].dis;
      smp();
      check($sformatf("vec%0d_grnt", i), grnt, vecs[i].exp_grnt);
      check($sformatf("vec%0d_sel", i), sel_l1, vecs[i].exp_sel);
      check($sformatf("vec%0d_busy", i), busy, 0);
      tick();
      clear_inputs();
    end
    pulse_reset();

    // Single request: entry 3 L1.
    l1_vpn[3*28 +: 28] = 28'h1234567;
    req_l1 = 8'h08;
    serve(3, 1'b1, 28'h1234567, 0, 28'hABCDEF0, 1'b0, 0);
    req_l1 = 8'h00;
    smp();
    check("single_back_idle", busy, 0);
    tick();

    // Round-robin with all entries requesting continuously.
    pulse_reset();
    for (int i = 0; i < 8; i++) l1_vpn[i*28 +: 28] = 28'h0100000 + 28'(i);
    req_l1 = 8'hFF;
    for (int n = 0; n < 9; n++)
      serve(n % 8, 1'b1, 28'h0100000 + 28'(n % 8), 0, 28'h0A00000 + 28'(n), n[0], 0);
    req_l1 = 8'h00;
    tick();

    // L1 beats L2, then the pointer wraps past 7 to find entry 0.
    pulse_reset();
    l1_vpn[5*28 +: 28] = 28'h5551111;
    l2_vpn[5*28 +: 28] = 28'h5552222;
    l1_vpn[0 +: 28]    = 28'h0000123;
    req_l1 = 8'h20; req_l2 = 8'h20;
    serve(5, 1'b1, 28'h5551111, 0, 28'h1111111, 1'b0, 0);
    req_l1 = 8'h00;
    serve(5, 1'b0, 28'h5552222, 0, 28'h2222222, 1'b1, 0);
    req_l2 = 8'h00;
    req_l1 = 8'h21;
    serve(0, 1'b1, 28'h0000123, 0, 28'h3333333, 1'b0, 0);
    req_l1 = 8'h00;
    tick();

    // Kill variants on entry 2.
    pulse_reset();
    l1_vpn[2*28 +: 28] = 28'h2020202;
    l2_vpn[2*28 +: 28] = 28'h2121212;
    req_l1 = 8'h04;
    serve(2, 1'b1, 28'h2020202, 0, 28'h4444444, 1'b0, 1);
    req_l1 = 8'h00;
    smp();
    check("kill_back_idle", busy, 0);
    tick();
    req_l2 = 8'h04;
    serve(2, 1'b0, 28'h2121212, 0, 28'h5555555, 1'b0, 2);
    req_l2 = 8'h00;
    req_l1 = 8'h04;
    serve(2, 1'b1, 28'h2020202, 2, 28'h6666666, 1'b0, 3);
    req_l1 = 8'h00;
    tick();

    // Backpressure: MMU withholds grant for 10 cycles.
    l1_vpn[4*28 +: 28] = 28'h4040404;
    req_l1 = 8'h10;
    serve(4, 1'b1, 28'h4040404, 10, 28'h7777777, 1'b0, 0);
    req_l1 = 8'h00;
    tick();

    // Disable blocks grants in IDLE; release lets the request through.
    req_l1 = 8'h10; mmu_dis = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("dis_no_grant", grnt, 0);
      check("dis_idle", busy, 0);
      tick();
    end
    mmu_dis = 1'b0;
    serve(4, 1'b1, 28'h4040404, 0, 28'h7070707, 1'b0, 0);
    req_l1 = 8'h00;
    tick();

    // Prefetch disable mid-flight and a stray response in REQ do not disturb the transaction.
    l1_vpn[6*28 +: 28] = 28'h6060606;
    req_l1 = 8'h40;
    smp();
    check("pref_grant", grnt, 8'h40);
    tick();
    req_l1 = 8'h00; pref_en = 1'b0; ppn_vld_in = 1'b1;
    smp();
    check("stray_req_vld", get_vld, 0);
    check("pref_off_req", lsu_req, 1);
    tick();
    ppn_vld_in = 1'b0; mmu_grnt = 1'b1;
    smp();
    check("pref_off_req_vpn", lsu_vpn, 28'h6060606);
    tick();
    mmu_grnt = 1'b0; ppn_vld_in = 1'b1; ppn_in = 28'h8888888; sec_in = 1'b0; share_in = 1'b0;
    exp_q.push_back({8'h40, 28'h8888888, 3'b000});
    smp();
    check("pref_off_resp", get_vld, 8'h40);
    tick();
    ppn_vld_in = 1'b0; pref_en = 1'b1;

    // Stray response in IDLE is ignored.
    ppn_vld_in = 1'b1;
    smp();
    check("stray_idle_vld", get_vld, 0);
    check("stray_idle_busy", busy, 0);
    tick();
    ppn_vld_in = 1'b0;

    // Reset in WAIT drops the transaction.
    l1_vpn[7*28 +: 28] = 28'h7070707;
    req_l1 = 8'h80;
    smp();
    check("rstw_grant", grnt, 8'h80);
    tick();
    req_l1 = 8'h00; mmu_grnt = 1'b1;
    tick();
    mmu_grnt = 1'b0;
    rst = 1'b1; req_l1 = 8'hFF;
    smp();
    check("rstw_busy", busy, 0);
    check("rstw_grnt", grnt, 0);
    check("rstw_req", lsu_req, 0);
    tick();
    rst = 1'b0; req_l1 = 8'h00; ppn_vld_in = 1'b1;
    smp();
    check("rstw_no_resp", get_vld, 0);
    check("rstw_idle", busy, 0);
    tick();
    ppn_vld_in = 1'b0;

`ifdef PFU_MMU_ARB_TIMEOUT_EN
    // Watchdog: silent WAIT ends with an error response; late response ignored.
    pulse_reset();
    l1_vpn[3*28 +: 28] = 28'h3030303;
    req_l1 = 8'h08;
    smp();
    check("to_grant", grnt, 8'h08);
    tick();
    req_l1 = 8'h00; mmu_grnt = 1'b1;
    tick();
    mmu_grnt = 1'b0;
    for (int k = 0; k < 255; k++) begin
      if (k == 254) begin
        smp();
        check("to_not_early", get_vld, 0);
      end
      tick();
    end
    exp_q.push_back({8'h08, ppn_in, 1'b1, sec_in, share_in});
    smp();
    check("to_vld", get_vld, 8'h08);
    check("to_err", get_err, 1);
    tick();
    repeat (4) tick();
    ppn_vld_in = 1'b1;
    smp();
    check("to_late_ignored", get_vld, 0);
    check("to_idle", busy, 0);
    tick();
    ppn_vld_in = 1'b0;
`endif

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
